// File: rtl/component_delay_var.sv
// Runtime-selectable register delay line for {valid, data} with stall, flush and delay-change discard.
// Optional macro COMPONENT_DELAY_VAR_STATS_EN adds a saturating drop_count output.
module component_delay_var #(
    parameter int WIDTH      = 8,
    parameter int MAX_CYCLES = 8,
    localparam int SEL_W     = $clog2(MAX_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             flush,
    input  logic [SEL_W-1:0] delay_sel,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
`ifdef COMPONENT_DELAY_VAR_STATS_EN
    output logic [15:0]      drop_count,
`endif
    output logic [SEL_W-1:0] cur_delay
);

    localparam logic [SEL_W-1:0] ONE_SEL = SEL_W'(1);
    localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_CYCLES);

    logic [MAX_CYCLES:1] vld;
    logic [MAX_CYCLES:1] vld_next;
    logic [WIDTH-1:0]    dat [1:MAX_CYCLES];
    logic [SEL_W-1:0]    sel_clamped;
    logic                delay_change;

    always_comb begin
        sel_clamped = delay_sel;
        if (delay_sel == '0) begin
            sel_clamped = ONE_SEL;
        end else if (delay_sel > MAX_SEL) begin
            sel_clamped = MAX_SEL;
        end
    end

    assign delay_change = (sel_clamped != cur_delay);

    // Flush drops everything including the same-cycle input; a delay change keeps only the new capture.
    always_comb begin
        vld_next = vld;
        if (en) begin
            for (int i = 2; i <= MAX_CYCLES; i++) begin
                vld_next[i] = vld[i-1];
            end
            vld_next[1] = in_valid;
        end
        if (flush) begin
            vld_next = '0;
        end else if (delay_change) begin
            vld_next    = '0;
            vld_next[1] = en & in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld       <= '0;
            cur_delay <= ONE_SEL;
        end else begin
            vld       <= vld_next;
            cur_delay <= sel_clamped;
        end
    end

    // Data bits carry no reset; the output mux masks them whenever the tap is invalid.
    always_ff @(posedge clk) begin
        if (en) begin
            dat[1] <= data_in;
            for (int i = 2; i <= MAX_CYCLES; i++) begin
                dat[i] <= dat[i-1];
            end
        end
    end

    always_comb begin
        out_valid = 1'b0;
        data_out  = '0;
        busy      = 1'b0;
        for (int i = 1; i <= MAX_CYCLES; i++) begin
            if (SEL_W'(i) == cur_delay) begin
                out_valid = vld[i];
                data_out  = vld[i] ? dat[i] : '0;
            end
            if (SEL_W'(i) <= cur_delay) begin
                busy = busy | vld[i];
            end
        end
    end

`ifdef COMPONENT_DELAY_VAR_STATS_EN
    logic [15:0] drop_n;
    logic [16:0] drop_sum;

    always_comb begin
        drop_n = '0;
        if (flush || delay_change) begin
            for (int i = 1; i <= MAX_CYCLES; i++) begin
                drop_n = drop_n + 16'(vld[i]);
            end
        end
        if (flush && en && in_valid) begin
            drop_n = drop_n + 16'd1;
        end
        drop_sum = {1'b0, drop_count} + {1'b0, drop_n};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            drop_count <= '0;
        end else begin
            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_component_delay_var.sv
// Directed table-driven bench for component_delay_var (WIDTH=8, MAX_CYCLES=8).
module tb_component_delay_var;

    localparam int WIDTH = 8;
    localparam int MAX_CYCLES = 8;
    localparam int SEL_W = $clog2(MAX_CYCLES + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic             flush = 1'b0;
    logic [SEL_W-1:0] delay_sel = '0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             out_valid;
    logic [WIDTH-1:0] data_out;
    logic             busy;
    logic [SEL_W-1:0] cur_delay;
`ifdef COMPONENT_DELAY_VAR_STATS_EN
    logic [15:0]      drop_count;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic       en;
        logic       flush;
        logic [3:0] sel;
        logic       iv;
        logic [7:0] din;
        logic       e_ov;
        logic [7:0] e_do;
        logic       e_busy;
        logic [3:0] e_cur;
        int         e_drop;
    } vec_t;

    vec_t vecs[$];

    component_delay_var #(.WIDTH(WIDTH), .MAX_CYCLES(MAX_CYCLES)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .delay_sel (delay_sel),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .out_valid (out_valid),
        .data_out  (data_out),
        .busy      (busy),
`ifdef COMPONENT_DELAY_VAR_STATS_EN
        .drop_count(drop_count),
`endif
        .cur_delay (cur_delay)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic e_ov, input logic [7:0] e_do,
                             input logic e_busy, input logic [3:0] e_cur);
        check_val({tag, " out_valid"}, int'(out_valid), int'(e_ov));
        check_val({tag, " data_out"}, int'(data_out), int'(e_do));
        check_val({tag, " busy"}, int'(busy), int'(e_busy));
        check_val({tag, " cur_delay"}, int'(cur_delay), int'(e_cur));
    endtask

    task automatic check_drop(input string tag, input int e_drop);
`ifdef COMPONENT_DELAY_VAR_STATS_EN
        check_val({tag, " drop_count"}, int'(drop_count), e_drop);
`else
        if (e_drop < 0) $display("note: %s", tag);
`endif
    endtask

    task automatic drive(input logic r, input logic e, input logic f, input logic [3:0] s,
                         input logic v, input logic [7:0] d);
        rst = r; en = e; flush = f; delay_sel = s; in_valid = v; data_in = d;
    endtask

    function automatic void add(input logic r, input logic e, input logic f, input logic [3:0] s,
                                input logic v, input logic [7:0] d, input logic eo,
                                input logic [7:0] ed, input logic eb, input logic [3:0] ec,
                                input int edr);
        vec_t t;
        t.rst = r; t.en = e; t.flush = f; t.sel = s; t.iv = v; t.din = d;
        t.e_ov = eo; t.e_do = ed; t.e_busy = eb; t.e_cur = ec; t.e_drop = edr;
        vecs.push_back(t);
    endfunction

    initial begin
        // Reset, then latency 3
        add(1, 1, 0, 3, 0, 8'h00, 0, 8'h00, 0, 1, 0);
        add(0, 1, 0, 3, 0, 8'h00, 0, 8'h00, 0, 3, 0);
        add(0, 1, 0, 3, 1, 8'hA5, 0, 8'h00, 1, 3, 0);
        add(0, 1, 0, 3, 0, 8'h00, 0, 8'h00, 1, 3, 0);
        add(0, 1, 0, 3, 0, 8'h00, 1, 8'hA5, 1, 3, 0);
        add(0, 1, 0, 3, 0, 8'h00, 0, 8'h00, 0, 3, 0);
        // delay_sel=0 clamps to 1; the change drops A5 still sitting in s4
        add(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        add(0, 1, 0, 0, 1, 8'h3C, 1, 8'h3C, 1, 1, 1);
        add(0, 1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 1, 1);
        // delay_sel=15 clamps to 8; change drops 3C in s2, captures 7E
        add(0, 1, 0, 15, 1, 8'h7E, 0, 8'h00, 1, 8, 2);
        for (int i = 0; i < 6; i++) add(0, 1, 0, 15, 0, 8'h00, 0, 8'h00, 1, 8, 2);
        add(0, 1, 0, 15, 0, 8'h00, 1, 8'h7E, 1, 8, 2);
        add(0, 1, 0, 15, 0, 8'h00, 0, 8'h00, 0, 8, 2);
        // Delay 4 -> 2 while 03 is captured
        add(0, 1, 0, 4, 0, 8'h00, 0, 8'h00, 0, 4, 2);
        add(0, 1, 0, 4, 1, 8'h01, 0, 8'h00, 1, 4, 2);
        add(0, 1, 0, 4, 1, 8'h02, 0, 8'h00, 1, 4, 2);
        add(0, 1, 0, 2, 1, 8'h03, 0, 8'h00, 1, 2, 4);
        add(0, 1, 0, 2, 1, 8'h04, 1, 8'h03, 1, 2, 4);
        add(0, 1, 0, 2, 1, 8'h05, 1, 8'h04, 1, 2, 4);
        add(0, 1, 0, 2, 0, 8'h00, 1, 8'h05, 1, 2, 4);
        add(0, 1, 0, 2, 0, 8'h00, 0, 8'h00, 0, 2, 4);
        // Go to 8 (drops 05/04/03 in s3..s5), three in flight, then flush with input
        add(0, 1, 0, 8, 0, 8'h00, 0, 8'h00, 0, 8, 7);
        add(0, 1, 0, 8, 1, 8'hA1, 0, 8'h00, 1, 8, 7);
        add(0, 1, 0, 8, 1, 8'hA2, 0, 8'h00, 1, 8, 7);
        add(0, 1, 0, 8, 1, 8'hA3, 0, 8'h00, 1, 8, 7);
        add(0, 1, 1, 8, 1, 8'hA4, 0, 8'h00, 0, 8, 11);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].sel, vecs[i].iv, vecs[i].din);
            tick();
            check_out(tag, vecs[i].e_ov, vecs[i].e_do, vecs[i].e_busy, vecs[i].e_cur);
            check_drop(tag, vecs[i].e_drop);
        end

        // Nothing emerges for MAX_CYCLES cycles after the flush
        for (int i = 0; i < MAX_CYCLES; i++) begin
            drive(0, 1, 0, 8, 0, 8'h00);
            tick();
            check_out($sformatf("post_flush%0d", i), 0, 8'h00, 0, 8);
        end

        // Stall: delay 4, capture 11, five stalled cycles with junk on the input
        drive(0, 1, 0, 4, 0, 8'h00);
        tick();
        check_out("stall_set", 0, 8'h00, 0, 4);
        drive(0, 1, 0, 4, 1, 8'h11);
        tick();
        check_out("stall_cap", 0, 8'h00, 1, 4);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 0, 4, 1, 8'hEE);
            tick();
            check_out($sformatf("stall_hold%0d", i), 0, 8'h00, 1, 4);
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 0, 4, 0, 8'h00);
            tick();
            check_out($sformatf("stall_run%0d", i), 0, 8'h00, 1, 4);
        end
        tick();
        check_out("stall_out", 1, 8'h11, 1, 4);
        tick();
        check_out("stall_gone", 0, 8'h00, 0, 4);
        check_drop("stall", 11);

        // Reset mid-stream at delay 5, then a fresh item at delay 5
        drive(0, 1, 0, 5, 0, 8'h00);
        tick();
        drive(0, 1, 0, 5, 1, 8'h21);
        tick();
        drive(0, 1, 0, 5, 1, 8'h22);
        tick();
        drive(0, 1, 0, 5, 1, 8'h23);
        tick();
        check_out("pre_rst", 0, 8'h00, 1, 5);
        drive(1, 1, 0, 5, 1, 8'h24);
        tick();
        check_out("rst_mid", 0, 8'h00, 0, 1);
        check_drop("rst_mid", 0);
        drive(0, 1, 0, 5, 0, 8'h00);
        tick();
        check_out("rst_resel", 0, 8'h00, 0, 5);
        drive(0, 1, 0, 5, 1, 8'h5A);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 5, 0, 8'h00);
            tick();
            check_out($sformatf("rst_wait%0d", i), 0, 8'h00, 1, 5);
        end
        tick();
        check_out("rst_new_out", 1, 8'h5A, 1, 5);
        tick();
        check_out("rst_new_gone", 0, 8'h00, 0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/component_delay_var.md
Name: component_delay_var

Overview:
- Parametrised successor to the fixed-length register delay line.
- Carries WIDTH-bit data plus a valid bit through up to MAX_CYCLES register stages.
- Latency is selected at runtime. Supports a stall (enable) and a synchronous flush.
- Used in datapaths where operand/result alignment latency differs per mode, e.g. matching multi-cycle functional-unit latencies.

Parameters:
- WIDTH, 8, data width in bits.
- MAX_CYCLES, 8, number of physical stages and maximum selectable delay; legal range is 1 or more.
- SEL_W, $clog2(MAX_CYCLES+1), width of delay_sel; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  advance enable; when 0 all stages hold.
- flush  input  1  synchronous clear of all in-flight valid bits.
- delay_sel  input  SEL_W  requested latency in enabled cycles.
- in_valid  input  1  data_in qualifier.
- data_in  input  WIDTH  input data.
- out_valid  output  1  data_out qualifier.
- data_out  output  WIDTH  delayed data.
- busy  output  1  1 when any valid item is in stages 1..cur_delay.
- cur_delay  output  SEL_W  latency currently in effect.

Behaviour:
- Storage: stages s[1..MAX_CYCLES], each a {valid, data} pair. s[0] is {in_valid, data_in}.
- Advance: on a rising clk edge with en=1, s[i] <= s[i-1] for i = 1..MAX_CYCLES.
- Stall: with en=0, all stages hold. in_valid/data_in are ignored (no capture, no backpressure signal; the upstream block must not present data while en=0).
- Output tap: {out_valid, data_out} = s[cur_delay], a mux of registered stages. No combinational path from data_in to data_out.
- Latency: an item captured at edge N, with en=1 on every following edge, appears at the output after edge N+cur_delay-1. That is, it is visible for the cycle following cur_delay enabled edges counted from and including the capture edge.
- data_out when out_valid=0: 0, forced by the output mux.
- delay_sel clamp: 0 is treated as 1; values above MAX_CYCLES are treated as MAX_CYCLES.
- cur_delay register: loads the clamped delay_sel every edge, regardless of en.
- Delay change: when clamped delay_sel != cur_delay at an edge, that edge loads the new cur_delay and clears the valid bits of s[1..MAX_CYCLES]. in_valid is still captured into s[1] if en=1. Data bits are not cleared.
- flush=1: clears all stage valid bits at the edge. The same-cycle input is dropped. flush takes priority over en and over capture.
- busy: OR of s[i].valid for i = 1..cur_delay. Stages beyond cur_delay are ignored.
- Reset (rst=1 at an edge), overriding all other inputs:
  - all valid bits cleared;
  - cur_delay <= 1;
  - out_valid=0, data_out=0, busy=0 in the following cycle.
- Reset applied mid-stream discards all in-flight items.

Optional Feature:
- Macro: COMPONENT_DELAY_VAR_STATS_EN.
- Defined: adds output drop_count (16-bit, saturating at 16'hFFFF).
  - Increments by the number of valid items discarded at an edge, from flush or from a delay change, counting stages 1..MAX_CYCLES.
  - A flushed same-cycle in_valid counts as 1 extra.
  - Cleared by rst only.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Test Plan:
- Basic latency: rst, then delay_sel=3, en=1. Drive in_valid=1 with data 8'hA5 for one cycle -> out_valid=1, data_out=8'hA5 exactly 3 cycles after capture, for one cycle; busy=1 in between.
- Stall: delay_sel=4, capture 8'h11 then hold en=0 for 5 cycles -> output is delayed by exactly 5 cycles; data_out=8'h11 appears for one cycle after 4 enabled edges.
- Clamp and max:
  - delay_sel=0 -> cur_delay=1; an item emerges 1 cycle after capture.
  - delay_sel=15 with MAX_CYCLES=8 -> cur_delay=8; latency 8.
- Delay change mid-stream: stream 8'h01..8'h05 at delay 4. Change delay_sel to 2 while 8'h03 is being captured -> 8'h01/8'h02 never appear. 8'h03 appears 2 cycles after capture, then 8'h04, 8'h05. With STATS: drop_count=2.
- Flush plus simultaneous input: 3 items in flight, assert flush with in_valid=1 -> no out_valid for the next MAX_CYCLES cycles; busy=0 next cycle. With STATS: drop_count=4.
- Reset mid-stream: rst during traffic at delay 5 -> out_valid=0, data_out=0, busy=0, cur_delay=1 the next cycle. A new item afterwards follows the delay then set by delay_sel.
